// File: rtl/lcd_timing_pkg.sv
// Shared definitions for the RGB LCD timing driver: panel timing presets,
// RGB565 colour constants and the power-up sequencer state encoding.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    S_PRST = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } pwr_state_t;

  typedef struct packed {
    logic [10:0] sync;
    logic [10:0] back;
    logic [10:0] disp;
    logic [10:0] front;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } panel_timing_t;

  localparam panel_timing_t PANEL_800X480 = '{
    h: '{sync: 11'd128, back: 11'd88,  disp: 11'd800,  front: 11'd40},
    v: '{sync: 11'd2,   back: 11'd33,  disp: 11'd480,  front: 11'd10}
  };
  localparam panel_timing_t PANEL_480X272 = '{
    h: '{sync: 11'd41,  back: 11'd2,   disp: 11'd480,  front: 11'd2},
    v: '{sync: 11'd10,  back: 11'd2,   disp: 11'd272,  front: 11'd2}
  };
  localparam panel_timing_t PANEL_1024X600 = '{
    h: '{sync: 11'd20,  back: 11'd140, disp: 11'd1024, front: 11'd160},
    v: '{sync: 11'd3,   back: 11'd20,  disp: 11'd600,  front: 11'd12}
  };

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  localparam int CNT_LIMIT = 2047;

  // Sum computed in int so an oversized preset is detectable rather than wrapping.
  function automatic int timing_sum(input logic [10:0] a, input logic [10:0] b,
                                    input logic [10:0] c, input logic [10:0] d);
    return int'(a) + int'(b) + int'(c) + int'(d);
  endfunction

endpackage

// File: rtl/lcd_power_seq.sv
// Panel power-up sequencer: holds lcd_rst low, waits a settle time after
// release, then raises run_en permanently until the next system reset.
module lcd_power_seq
  import lcd_timing_pkg::*;
#(
  parameter logic [19:0] RST_CYC  = 20'd50000,
  parameter logic [19:0] INIT_CYC = 20'd100000
) (
  input  logic lcd_clk,
  input  logic sys_rst_n,
  output logic lcd_rst,
  output logic run_en
);

  pwr_state_t  state;
  logic [19:0] dly_cnt;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_PRST;
      dly_cnt <= '0;
      lcd_rst <= 1'b0;
      run_en  <= 1'b0;
    end else begin
      case (state)
        S_PRST: begin
          if (dly_cnt == RST_CYC - 20'd1) begin
            state   <= S_INIT;
            dly_cnt <= '0;
            lcd_rst <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 20'd1;
          end
        end
        S_INIT: begin
          if (dly_cnt == INIT_CYC - 20'd1) begin
            state   <= S_RUN;
            dly_cnt <= '0;
            run_en  <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 20'd1;
          end
        end
        S_RUN:   run_en <= 1'b1;
        default: state  <= S_PRST;
      endcase
    end
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// RGB LCD timing generator: h/v counters, sync/DE decode, one-cycle pixel
// coordinate lookahead for the pixel source, and panel power/backlight control.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter logic [10:0] H_SYNC   = PANEL_800X480.h.sync,
  parameter logic [10:0] H_BACK   = PANEL_800X480.h.back,
  parameter logic [10:0] H_DISP   = PANEL_800X480.h.disp,
  parameter logic [10:0] H_FRONT  = PANEL_800X480.h.front,
  parameter logic [10:0] V_SYNC   = PANEL_800X480.v.sync,
  parameter logic [10:0] V_BACK   = PANEL_800X480.v.back,
  parameter logic [10:0] V_DISP   = PANEL_800X480.v.disp,
  parameter logic [10:0] V_FRONT  = PANEL_800X480.v.front,
  parameter logic [19:0] RST_CYC  = 20'd50000,
  parameter logic [19:0] INIT_CYC = 20'd100000
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic [15:0] lcd_rgb,
  output logic        lcd_rst,
  output logic        lcd_bl,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL    = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL    = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] H_ACT_BEG  = H_SYNC + H_BACK;
  localparam logic [10:0] H_ACT_END  = H_ACT_BEG + H_DISP;
  localparam logic [10:0] H_LOOK_BEG = H_ACT_BEG - 11'd1;
  localparam logic [10:0] H_LOOK_END = H_ACT_END - 11'd1;
  localparam logic [10:0] V_ACT_BEG  = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT_END  = V_ACT_BEG + V_DISP;

  // The lookahead window starts one column before DE, so sync+back porch must be non-zero.
  if (timing_sum(H_SYNC, H_BACK, H_DISP, H_FRONT) > CNT_LIMIT ||
      timing_sum(V_SYNC, V_BACK, V_DISP, V_FRONT) > CNT_LIMIT ||
      timing_sum(H_SYNC, H_BACK, 11'd0, 11'd0) < 1 ||
      RST_CYC == 20'd0 || INIT_CYC == 20'd0) begin : g_bad_params
    $error("lcd_timing_driver: illegal timing parameters");
  end

  logic        run_en;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        hact;
  logic        vact;
  logic        look;

  lcd_power_seq #(
    .RST_CYC  (RST_CYC),
    .INIT_CYC (INIT_CYC)
  ) u_power_seq (
    .lcd_clk   (lcd_clk),
    .sys_rst_n (sys_rst_n),
    .lcd_rst   (lcd_rst),
    .run_en    (run_en)
  );

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 11'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 11'd1) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Backlight comes on once the first frame has begun and stays on.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcd_bl <= 1'b0;
    end else if (frame_start) begin
      lcd_bl <= 1'b1;
    end
  end

  always_comb begin
    hact        = run_en && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    vact        = run_en && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    look        = vact && (h_cnt >= H_LOOK_BEG) && (h_cnt < H_LOOK_END);
    lcd_hs      = ~(run_en && (h_cnt < H_SYNC));
    lcd_vs      = ~(run_en && (v_cnt < V_SYNC));
    lcd_de      = hact && vact;
    lcd_rgb     = lcd_de ? pixel_data : RGB_BLACK;
    pixel_xpos  = look ? (h_cnt - H_LOOK_BEG) : 11'd0;
    pixel_ypos  = vact ? (v_cnt - V_ACT_BEG) : 11'd0;
    frame_start = run_en && (h_cnt == 11'd0) && (v_cnt == 11'd0);
  end

endmodule
